// File: rtl/alu_secuencial_if.sv
// alu_secuencial_if: request/result bus of alu_secuencial; master = requester/consumer, slave = ALU
interface alu_secuencial_if #(
  parameter int WIDTH = 8,
  parameter int SHW = $clog2(WIDTH)
);
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [WIDTH-1:0] A, B, Resultado;
  logic [2:0] ALUcontrol;
  logic [SHW-1:0] MovLeft, MovRight;
  logic [3:0] ALU_flags;
  modport master (
    output in_valid, A, B, ALUcontrol, MovLeft, MovRight, out_ready,
    input in_ready, out_valid, Resultado, ALU_flags, busy
  );
  modport slave (
    input in_valid, A, B, ALUcontrol, MovLeft, MovRight, out_ready,
    output in_ready, out_valid, Resultado, ALU_flags, busy
  );
endinterface

// File: rtl/alu_secuencial.sv
// alu_secuencial: multi-cycle ALU (add/sub/and/or, optional 1-bit-per-cycle shift); ports clk, rst (async), clr (sync abort), bus (slave side of alu_secuencial_if)
module alu_secuencial #(
  parameter int WIDTH = 8,
  parameter int SHW = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst,
  input logic clr,
  alu_secuencial_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] a_r, b_r, res, bb, base;
  logic [WIDTH:0] sum;
  logic [2:0] op_r;
  logic [SHW-1:0] cnt;
  logic [3:0] flags;
  logic c_r, v_r, ov_r, sub, arith, ovf;
  assign sub = op_r[0] & (op_r[2] | ~op_r[1]);
  assign arith = op_r[2] | ~op_r[1];
  assign bb = sub ? ~b_r : b_r;
  assign sum = {1'b0, a_r} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
  assign ovf = (a_r[WIDTH-1] == bb[WIDTH-1]) & (sum[WIDTH-1] != a_r[WIDTH-1]);
  assign base = arith ? sum[WIDTH-1:0] : (op_r[0] ? a_r | b_r : a_r & b_r);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = bus.in_valid ? EXEC : IDLE;
      EXEC: nxt = (op_r[2] && cnt != '0) ? SHIFT : DONE;
      SHIFT: nxt = (cnt == SHW'(1)) ? DONE : SHIFT;
      DONE: nxt = (ov_r && bus.out_ready) ? IDLE : DONE;
    endcase
    if (clr) nxt = IDLE;
  end
  // The first DONE cycle registers N/Z from the final result; out_valid rises with the flags.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      op_r <= '0;
      cnt <= '0;
      res <= '0;
      flags <= '0;
      c_r <= 1'b0;
      v_r <= 1'b0;
      ov_r <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid && !clr) begin
        a_r <= bus.A;
        b_r <= bus.B;
        op_r <= bus.ALUcontrol;
        cnt <= bus.ALUcontrol[2] ? (bus.ALUcontrol[1] ? bus.MovLeft : bus.MovRight) : '0;
      end
      if (state == EXEC && !clr) begin
        res <= base;
        c_r <= arith & sum[WIDTH];
        v_r <= arith & ovf;
      end
      if (state == SHIFT && !clr) begin
        res <= op_r[1] ? res << 1 : res >> 1;
        cnt <= cnt - SHW'(1);
      end
      if (state == DONE && !ov_r && !clr) flags <= {res[WIDTH-1], ~|res, c_r, v_r};
      ov_r <= state == DONE && !clr && !(ov_r && bus.out_ready);
    end
  assign bus.in_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.out_valid = ov_r;
  assign bus.Resultado = res;
  assign bus.ALU_flags = flags;
endmodule

// File: tb/tb_alu_secuencial.sv
// tb_alu_secuencial: directed self-checking bench for alu_secuencial (WIDTH=8)
module tb_alu_secuencial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  alu_secuencial_if #(.WIDTH(8)) bus();
  alu_secuencial #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] ml, input logic [2:0] mr,
                        input logic [7:0] er, input logic [3:0] ef, input int el);
    int cycles;
    @(posedge clk); #1;
    check("in_ready_idle", bus.in_ready, 1);
    bus.ALUcontrol = op;
    bus.A = a;
    bus.B = b;
    bus.MovLeft = ml;
    bus.MovRight = mr;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cycles = 0;
    while (!bus.out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    check($sformatf("lat_op%0d", op), cycles, el);
    check($sformatf("res_op%0d", op), bus.Resultado, er);
    check($sformatf("flags_op%0d", op), bus.ALU_flags, ef);
    check("in_ready_done", bus.in_ready, 0);
    @(posedge clk); #1;
    check("ov_after_take", bus.out_valid, 0);
    check("in_ready_after", bus.in_ready, 1);
  endtask
  initial begin
    int cnt_ov;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.A = '0;
    bus.B = '0;
    bus.ALUcontrol = '0;
    bus.MovLeft = '0;
    bus.MovRight = '0;
    #3;
    check("rst_res", bus.Resultado, 0);
    check("rst_flags", bus.ALU_flags, 0);
    check("rst_ov", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rdy_after_rst", bus.in_ready, 1);
    run_op(3'd0, 8'h7F, 8'h01, 3'd0, 3'd0, 8'h80, 4'b1001, 2);
    run_op(3'd1, 8'h05, 8'h05, 3'd0, 3'd0, 8'h00, 4'b0110, 2);
    run_op(3'd2, 8'hF0, 8'h3C, 3'd0, 3'd0, 8'h30, 4'b0000, 2);
    run_op(3'd3, 8'hF0, 8'h0C, 3'd0, 3'd0, 8'hFC, 4'b1000, 2);
    run_op(3'd6, 8'h03, 8'h01, 3'd3, 3'd5, 8'h20, 4'b0000, 5);
    run_op(3'd5, 8'h10, 8'h30, 3'd2, 3'd4, 8'h0E, 4'b0000, 6);
    run_op(3'd4, 8'hFF, 8'h01, 3'd6, 3'd1, 8'h00, 4'b0110, 3);
    run_op(3'd7, 8'h01, 8'h02, 3'd7, 3'd3, 8'h80, 4'b1000, 9);
    run_op(3'd0, 8'h80, 8'h80, 3'd3, 3'd3, 8'h00, 4'b0111, 2);
    run_op(3'd4, 8'h40, 8'h40, 3'd5, 3'd0, 8'h80, 4'b1001, 2);
    // backpressure: hold the result for 3 cycles while in_valid pulses
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.ALUcontrol = 3'd1;
    bus.A = 8'h03;
    bus.B = 8'h05;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cnt_ov = 0;
    while (!bus.out_valid && cnt_ov < 40) begin
      @(posedge clk); #1;
      cnt_ov++;
    end
    check("bp_lat", cnt_ov, 2);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.A = 8'hAA;
      bus.ALUcontrol = 3'd2;
      @(posedge clk); #1;
      check("bp_res", bus.Resultado, 8'hFE);
      check("bp_flags", bus.ALU_flags, 4'b1000);
      check("bp_ov", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ov", bus.out_valid, 0);
    check("bp_release_rdy", bus.in_ready, 1);
    @(posedge clk); #1;
    check("bp_no_accept", bus.busy, 0);
    // async reset in the middle of a shift
    bus.ALUcontrol = 3'd7;
    bus.A = 8'h01;
    bus.B = 8'h02;
    bus.MovLeft = 3'd7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_res", bus.Resultado, 0);
    check("midrst_flags", bus.ALU_flags, 0);
    check("midrst_ov", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    #2;
    rst = 1'b0;
    cnt_ov = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.out_valid) cnt_ov++;
    end
    check("rst_no_ov", cnt_ov, 0);
    run_op(3'd0, 8'h12, 8'h34, 3'd0, 3'd0, 8'h46, 4'b0000, 2);
    run_op(3'd3, 8'hF0, 8'h0C, 3'd0, 3'd0, 8'hFC, 4'b1000, 2);
    // clr during shift
    bus.ALUcontrol = 3'd7;
    bus.A = 8'h01;
    bus.B = 8'h02;
    bus.MovLeft = 3'd7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("pre_clr_busy", bus.busy, 1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_busy", bus.busy, 0);
    check("clr_rdy", bus.in_ready, 1);
    check("clr_flags_kept", bus.ALU_flags, 4'b1000);
    cnt_ov = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy) cnt_ov++;
    end
    check("clr_no_ov", cnt_ov, 0);
    // clr together with in_valid in IDLE
    clr = 1'b1;
    bus.ALUcontrol = 3'd0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_req_busy", bus.busy, 0);
    cnt_ov = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy) cnt_ov++;
    end
    check("clr_req_ignored", cnt_ov, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
